// File: rtl/tmr_vote_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tmr_vote_ctrl_pkg
// Shared definitions for the TMR vote controller.
//   state_t     : controller FSM encoding (IDLE / VOTE / OUT)
//   CH_A..CH_C  : channel index constants; bit i of fault_mask maps to channel i
//   n_healthy() : number of unmasked channels in a 3-bit fault mask
// -----------------------------------------------------------------------------
package tmr_vote_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VOTE = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

  // Counts the zero bits of the mask (a zero bit is a healthy channel).
  function automatic logic [1:0] n_healthy(input logic [2:0] i_mask);
    return 2'(!i_mask[0]) + 2'(!i_mask[1]) + 2'(!i_mask[2]);
  endfunction

endpackage

// File: rtl/tmr_vote_ctrl_maj3_vec.sv
// -----------------------------------------------------------------------------
// maj3_vec
// Purely combinational bitwise 2-of-3 majority over three WIDTH-bit words.
//   i_a, i_b, i_c : input words
//   o_maj         : per-bit majority (a&b)|(b&c)|(a&c)
// -----------------------------------------------------------------------------
module maj3_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_maj
);

  assign o_maj = (i_a & i_b) | (i_b & i_c) | (i_a & i_c);

endmodule

// File: rtl/tmr_vote_ctrl.sv
// -----------------------------------------------------------------------------
// tmr_vote_ctrl
// Sequencing controller for a TMR vote path. Captures three redundant channel
// words, votes them (registered), returns the result over a valid/ready
// handshake and retires channels that disagree FAULT_LIMIT times in a row.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (accepted only in IDLE)
//   ch_a, ch_b, ch_c    : redundant channel words
//   out_valid/out_ready : result handshake
//   out_data, out_err   : voted word, set err when no two-channel agreement
//   fault_mask          : {c,b,a}, set bit = channel retired
//   clr_fault           : clears fault_mask and all mismatch counters
// -----------------------------------------------------------------------------
module tmr_vote_ctrl
  import tmr_vote_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FAULT_LIMIT = 3,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ch_a,
  input  logic [WIDTH-1:0] ch_b,
  input  logic [WIDTH-1:0] ch_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [2:0]       fault_mask,
  input  logic             clr_fault
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAULT_LIMIT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_word [3];
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_err;
  logic [2:0]         r_mask;
  logic [CNT_W-1:0]   r_cnt [3];

  logic [WIDTH-1:0]   w_maj;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_vote_data;
  logic               w_vote_err;
  logic [2:0]         w_mask_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt [3];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_VOTE;
      ST_VOTE:                w_state_nxt = ST_OUT;
      ST_OUT:  if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Vote datapath
  // ---------------------------------------------------------------------------
  maj3_vec #(.WIDTH(WIDTH)) u_maj (
    .i_a   (r_word[CH_A]),
    .i_b   (r_word[CH_B]),
    .i_c   (r_word[CH_C]),
    .o_maj (w_maj)
  );

  // w_lo / w_hi are the lowest- and highest-index healthy words. With two
  // healthy channels they are the two voters; with one they coincide.
  always_comb begin
    w_lo        = '0;
    w_hi        = '0;
    w_vote_data = r_word[CH_A];
    w_vote_err  = 1'b1;
    for (int i = 2; i >= 0; i--) if (!r_mask[i]) w_lo = r_word[i];
    for (int i = 0; i <= 2; i++) if (!r_mask[i]) w_hi = r_word[i];
    case (n_healthy(r_mask))
      2'd3: begin w_vote_data = w_maj; w_vote_err = 1'b0;          end
      2'd2: begin w_vote_data = w_lo;  w_vote_err = (w_lo != w_hi); end
      2'd1: begin w_vote_data = w_lo;  w_vote_err = 1'b1;          end
      default: ;
    endcase
  end

  // Healthy channels count consecutive mismatches against the voted word;
  // reaching the limit retires the channel, after which its counter freezes.
  always_comb begin
    w_mask_nxt = r_mask;
    for (int i = 0; i <= 2; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (!r_mask[i]) begin
        if (r_word[i] == w_vote_data)  w_cnt_nxt[i] = '0;
        else if (r_cnt[i] < LIMIT)     w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        if (w_cnt_nxt[i] == LIMIT)     w_mask_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word     <= '{default: '0};
      r_out_data <= '0;
      r_out_err  <= 1'b0;
      r_mask     <= '0;
      r_cnt      <= '{default: '0};
    end else begin
      if (r_state == ST_IDLE && in_valid) begin
        r_word[CH_A] <= ch_a;
        r_word[CH_B] <= ch_b;
        r_word[CH_C] <= ch_c;
      end
      // The result uses the pre-clear mask even if clr_fault coincides.
      if (r_state == ST_VOTE) begin
        r_out_data <= w_vote_data;
        r_out_err  <= w_vote_err;
      end
      if (clr_fault) begin
        r_mask <= '0;
        r_cnt  <= '{default: '0};
      end else if (r_state == ST_VOTE) begin
        r_mask <= w_mask_nxt;
        r_cnt  <= w_cnt_nxt;
      end
    end
  end

  // in_ready is forced low combinationally while reset is held.
  assign in_ready   = (r_state == ST_IDLE) && !rst;
  assign out_valid  = (r_state == ST_OUT);
  assign out_data   = r_out_data;
  assign out_err    = r_out_err;
  assign fault_mask = r_mask;

endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tmr_vote_ctrl
// Directed bench for tmr_vote_ctrl: reset, vote rules, counter/mask behaviour,
// backpressure, clear-vs-vote priority and reset during OUT.
// -----------------------------------------------------------------------------
module tb_tmr_vote_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ch_a, ch_b, ch_c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic [2:0] fault_mask;
  logic       clr_fault;

  int checks   = 0;
  int failures = 0;

  tmr_vote_ctrl #(.WIDTH(8), .FAULT_LIMIT(3), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ch_a       (ch_a),
    .ch_b       (ch_b),
    .ch_c       (ch_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .fault_mask (fault_mask),
    .clr_fault  (clr_fault)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [3:0] ec);
    check({tag, "_cnt_a"}, 32'(dut.r_cnt[0]), 32'(ea));
    check({tag, "_cnt_b"}, 32'(dut.r_cnt[1]), 32'(eb));
    check({tag, "_cnt_c"}, 32'(dut.r_cnt[2]), 32'(ec));
  endtask

  // Handshake a triple, then check VOTE (no valid) and OUT (result valid).
  task automatic send(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] exp_d, input logic exp_e);
    ch_a = a; ch_b = b; ch_c = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; ch_a = 8'hxx; ch_b = 8'hxx; ch_c = 8'hxx;
    check({tag, "_vote_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_vote_ready"}, 32'(in_ready), 32'd0);
    tick();
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out_data"}, 32'(out_data), 32'(exp_d));
    check({tag, "_out_err"}, 32'(out_err), 32'(exp_e));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_fault = 1'b0;
    ch_a = '0; ch_b = '0; ch_c = '0;

    // Reset held for two edges.
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mask", 32'(fault_mask), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Single-channel upset: c outvoted.
    send("upset", 8'h0F, 8'h0F, 8'hF0, 8'h0F, 1'b0);
    check_cnt("upset", 4'd0, 4'd0, 4'd1);
    release_out("upset");

    // Bitwise vote: every channel differs from 0xE8.
    send("bitwise", 8'hAA, 8'hCC, 8'hF0, 8'hE8, 1'b0);
    check_cnt("bitwise", 4'd1, 4'd1, 4'd2);
    check("bitwise_mask", 32'(fault_mask), 32'd0);
    release_out("bitwise");

    // Clear in IDLE.
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("clr_idle_mask", 32'(fault_mask), 32'd0);
    check_cnt("clr_idle", 4'd0, 4'd0, 4'd0);

    // Fault retirement of c after three consecutive mismatches.
    send("ret1", 8'h55, 8'h55, 8'h00, 8'h55, 1'b0);
    check("ret1_mask", 32'(fault_mask), 32'd0);
    release_out("ret1");
    send("ret2", 8'h55, 8'h55, 8'h00, 8'h55, 1'b0);
    check("ret2_mask", 32'(fault_mask), 32'd0);
    check_cnt("ret2", 4'd0, 4'd0, 4'd2);
    release_out("ret2");
    send("ret3", 8'h55, 8'h55, 8'h00, 8'h55, 1'b0);
    check("ret3_mask", 32'(fault_mask), 32'b100);
    check_cnt("ret3", 4'd0, 4'd0, 4'd3);
    release_out("ret3");

    // Two healthy, disagreeing: lower index wins, err set, c frozen.
    send("two_diff", 8'h11, 8'h22, 8'h33, 8'h11, 1'b1);
    check_cnt("two_diff", 4'd0, 4'd1, 4'd3);
    release_out("two_diff");

    // Backpressure: result held for 5 cycles, in_valid pulses ignored.
    send("bp", 8'h3C, 8'h3C, 8'h99, 8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      ch_a = 8'hA0 + 8'(i); ch_b = 8'hB0; ch_c = 8'hC0;
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h3C);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    tick();
    check("bp_idle_stays", 32'(out_valid), 32'd0);
    check_cnt("bp", 4'd0, 4'd0, 4'd3);

    // Clear coinciding with a VOTE that would retire b.
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    send("clrv1", 8'h77, 8'h00, 8'h77, 8'h77, 1'b0);
    release_out("clrv1");
    send("clrv2", 8'h77, 8'h00, 8'h77, 8'h77, 1'b0);
    check_cnt("clrv2", 4'd0, 4'd2, 4'd0);
    release_out("clrv2");
    ch_a = 8'h77; ch_b = 8'h00; ch_c = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check("clrv3_valid", 32'(out_valid), 32'd1);
    check("clrv3_data", 32'(out_data), 32'h77);
    check("clrv3_err", 32'(out_err), 32'd0);
    check("clrv3_mask", 32'(fault_mask), 32'd0);
    check_cnt("clrv3", 4'd0, 4'd0, 4'd0);
    release_out("clrv3");

    // Reset while in OUT drops the pending result.
    send("rstout", 8'h12, 8'h12, 8'h13, 8'h12, 1'b0);
    check_cnt("rstout", 4'd0, 4'd0, 4'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstout_valid", 32'(out_valid), 32'd0);
    check("rstout_data", 32'(out_data), 32'd0);
    check("rstout_mask", 32'(fault_mask), 32'd0);
    check_cnt("rstout", 4'd0, 4'd0, 4'd0);
    tick();
    check("rstout_idle_valid", 32'(out_valid), 32'd0);
    check("rstout_idle_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmr_vote_ctrl.md
Name: tmr_vote_ctrl

Overview:
Sequencing controller for a triple-modular-redundancy (TMR) vote path.
- Captures three redundant WIDTH-bit channel words through a valid/ready handshake.
- Runs a registered bitwise 2-of-3 majority vote and returns the result through a second valid/ready handshake.
- Tracks consecutive per-channel disagreements and retires a channel once it reaches FAULT_LIMIT.
- Sits between the redundant producers and a single downstream consumer.

Parameters:
WIDTH, 8, data width of each channel and of the result
FAULT_LIMIT, 3, consecutive mismatches that mask a channel (range 1..2^CNT_W-1)
CNT_W, 4, width of each per-channel mismatch counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  channel words are valid
in_ready  output  1  controller can accept a new triple
ch_a  input  WIDTH  channel 0 word
ch_b  input  WIDTH  channel 1 word
ch_c  input  WIDTH  channel 2 word
out_valid  output  1  out_data and out_err are valid
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  voted result
out_err  output  1  result is not backed by a two-channel agreement
fault_mask  output  3  bit i set means channel i is retired ({c,b,a})
clr_fault  input  1  clears fault_mask and all counters

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, in_ready=0 while rst is asserted, out_valid=0, out_data=0, out_err=0, fault_mask=0, counters=0. Reset wins over every other event in any state, and any in-flight transaction is discarded.
- The FSM has three states: IDLE, VOTE and OUT.
  - IDLE: in_ready=1. When in_valid=1, register ch_a/ch_b/ch_c and go to VOTE.
  - VOTE: in_ready=0. Compute the result and register it into out_data and out_err. Update counters and mask. Go to OUT.
  - OUT: out_valid=1 and in_ready=0. out_data and out_err stay stable until out_ready=1, then go to IDLE with out_valid=0 on the next cycle.
- Latency and throughput: handshake at edge t gives out_valid=1 from edge t+2. With out_ready held at 1, one triple is accepted every 3 cycles.
- Vote rules, by number of healthy (unmasked) channels:
  - 3 healthy: out_data = (a&b)|(b&c)|(a&c) bitwise, out_err=0.
  - 2 healthy, words equal: out_data = that word, out_err=0.
  - 2 healthy, words differ: out_data = the lower-index healthy channel, out_err=1.
  - 1 healthy: out_data = that channel, out_err=1.
  - 0 healthy: out_data = ch_a, out_err=1.
- Counters update in VOTE, for healthy channels only:
  - A channel mismatches when its full word != out_data.
  - Mismatch increments the counter, saturating at FAULT_LIMIT. A match clears it to 0.
  - When the counter reaches FAULT_LIMIT, the mask bit is set in the same update. It is visible from the OUT cycle and applies to the next vote.
  - Counters of masked channels freeze.
- clr_fault: synchronous, takes effect in any state, and clears fault_mask and all counters. If it coincides with a VOTE update, the clear wins (counters=0, mask=0). The result being registered in that same VOTE cycle still uses the pre-clear mask.
- in_valid is ignored outside IDLE. Channel inputs need only be stable at the handshake edge.

Decomposition:
- Shared package holds the state encoding (IDLE=2'd0, VOTE=2'd1, OUT=2'd2) and the channel index constants CH_A=0, CH_B=1, CH_C=2.
- One sub-module, maj3_vec: purely combinational WIDTH-bit bitwise 2-of-3 majority over three words. It is instantiated once in the VOTE datapath; masking and selection logic stays in the controller.

Test Plan:
- Reset then idle: hold rst 2 cycles -> out_valid=0, fault_mask=3'b000, in_ready=0 during rst and 1 on the first cycle after.
- Single-channel upset: a=0x0F, b=0x0F, c=0xF0 -> out_data=0x0F, out_err=0, out_valid exactly 2 cycles after the handshake; channel c counter=1, others 0.
- Bitwise vote: a=0xAA, b=0xCC, c=0xF0 -> out_data=0xE8, out_err=0; all three counters increment.
- Fault retirement: c disagrees on 3 consecutive triples (a=b=0x55, c=0x00) -> fault_mask=3'b100 from the third OUT cycle. Next triple a=0x11, b=0x22, c=0x33 -> out_data=0x11, out_err=1, and c's counter does not change.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid=1, out_data unchanged, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE and in_ready=1 on the next cycle.
- Clear and reset mid-operation:
  - Assert clr_fault in the same cycle as a VOTE that would set a mask bit -> fault_mask=0 and counters=0 afterwards.
  - Assert rst while in OUT -> out_valid=0 the next cycle and the pending result is lost.
